// File: rtl/alu_pkg.sv
// Shared opcodes, pulse-vector bit positions, flag indices and FSM states for the
// accumulator ALU command front-end.
package alu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned NPULSE = 10;

    localparam int unsigned OPC_CLR = 0;
    localparam int unsigned OPC_ADD = 1;
    localparam int unsigned OPC_SUB = 2;
    localparam int unsigned OPC_MUL = 3;
    localparam int unsigned OPC_DIV = 4;
    localparam int unsigned OPC_SHR = 5;
    localparam int unsigned OPC_SHL = 6;
    localparam int unsigned OPC_AND = 7;
    localparam int unsigned OPC_OR  = 8;
    localparam int unsigned OPC_NOT = 9;
    localparam int unsigned OPC_LDA = 10;

    // Pulse vector bit -> ALU control line: c8,c9,c13,c15..c21
    localparam int unsigned P_CLR = 0;
    localparam int unsigned P_ADD = 1;
    localparam int unsigned P_SUB = 2;
    localparam int unsigned P_MUL = 3;
    localparam int unsigned P_DIV = 4;
    localparam int unsigned P_SHR = 5;
    localparam int unsigned P_SHL = 6;
    localparam int unsigned P_AND = 7;
    localparam int unsigned P_OR  = 8;
    localparam int unsigned P_NOT = 9;

    localparam int unsigned FLAG_ZF = 3;
    localparam int unsigned FLAG_CF = 2;
    localparam int unsigned FLAG_OF = 1;
    localparam int unsigned FLAG_SF = 0;

    typedef logic [NPULSE-1:0] pulse_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_EXEC2 = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: one-hot first-step pulse, legal bit, and two-step (LDA) bit.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int unsigned OPC_W = alu_pkg::OPC_W
) (
    input  logic [OPC_W-1:0] opc,
    output pulse_t           pulse_c,
    output logic             legal_c,
    output logic             two_step_c
);

    always_comb begin
        pulse_c    = '0;
        legal_c    = 1'b1;
        two_step_c = 1'b0;
        case (32'(opc))
            OPC_CLR: pulse_c[P_CLR] = 1'b1;
            OPC_ADD: pulse_c[P_ADD] = 1'b1;
            OPC_SUB: pulse_c[P_SUB] = 1'b1;
            OPC_MUL: pulse_c[P_MUL] = 1'b1;
            OPC_DIV: pulse_c[P_DIV] = 1'b1;
            OPC_SHR: pulse_c[P_SHR] = 1'b1;
            OPC_SHL: pulse_c[P_SHL] = 1'b1;
            OPC_AND: pulse_c[P_AND] = 1'b1;
            OPC_OR:  pulse_c[P_OR]  = 1'b1;
            OPC_NOT: pulse_c[P_NOT] = 1'b1;
            // LDA = clear, then add the operand on the following cycle
            OPC_LDA: begin
                pulse_c[P_CLR] = 1'b1;
                two_step_c     = 1'b1;
            end
            default: legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_issue.sv
// Command front-end for the accumulator ALU: accepts opcode+operand, issues registered
// control pulses, captures ACC/flags into a valid/ready response. Option: ALU_DIVZERO_TRAP_EN.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned OPC_W  = alu_pkg::OPC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OPC_W-1:0]  cmd_opc,
    input  logic [DATA_W-1:0] cmd_operand,
    output logic [DATA_W-1:0] br_out,
    output logic              c8,
    output logic              c9,
    output logic              c13,
    output logic              c15,
    output logic              c16,
    output logic              c17,
    output logic              c18,
    output logic              c19,
    output logic              c20,
    output logic              c21,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              rsp_err
);

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                lda_q, lda_d;
    pulse_t              pulse_q, pulse_d;
    logic [DATA_W-1:0]   br_q, br_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                err_q, err_d;

    pulse_t              dec_pulse_c;
    logic                legal_c;
    logic                two_step_c;
    logic                trap_c;
    logic                accept_c;

    alu_op_decode #(.OPC_W(OPC_W)) u_decode (
        .opc        (cmd_opc),
        .pulse_c    (dec_pulse_c),
        .legal_c    (legal_c),
        .two_step_c (two_step_c)
    );

`ifdef ALU_DIVZERO_TRAP_EN
    assign trap_c = (cmd_opc == OPC_W'(OPC_DIV)) && (cmd_operand == '0);
`else
    assign trap_c = 1'b0;
`endif

    // ready_q is only ever high in IDLE, so it alone qualifies the handshake
    assign accept_c = cmd_valid && ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            lda_q   <= 1'b0;
            pulse_q <= '0;
            br_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            lda_q   <= lda_d;
            pulse_q <= pulse_d;
            br_q    <= br_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        lda_d   = lda_q;
        pulse_d = '0;
        br_d    = br_q;
        valid_d = valid_q;
        data_d  = data_q;
        flags_d = flags_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    br_d = cmd_operand;
                    if (!legal_c || trap_c) begin
                        // Nothing issued: report the untouched ACC with an error
                        state_d = ST_RESP;
                        valid_d = 1'b1;
                        data_d  = alu_out;
                        flags_d = alu_flags;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                        pulse_d = dec_pulse_c;
                        lda_d   = two_step_c;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (lda_q) begin
                    state_d        = ST_EXEC2;
                    pulse_d[P_ADD] = 1'b1;
                end else begin
                    state_d = ST_CAPT;
                end
            end
            ST_EXEC2: begin
                state_d = ST_CAPT;
                lda_d   = 1'b0;
            end
            ST_CAPT: begin
                state_d = ST_RESP;
                valid_d = 1'b1;
                data_d  = alu_out;
                flags_d = alu_flags;
                err_d   = 1'b0;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign cmd_ready = ready_q;
    assign br_out    = br_q;
    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;
    assign rsp_flags = flags_q;
    assign rsp_err   = err_q;

    assign c8  = pulse_q[P_CLR];
    assign c9  = pulse_q[P_ADD];
    assign c13 = pulse_q[P_SUB];
    assign c15 = pulse_q[P_MUL];
    assign c16 = pulse_q[P_DIV];
    assign c17 = pulse_q[P_SHR];
    assign c18 = pulse_q[P_SHL];
    assign c19 = pulse_q[P_AND];
    assign c20 = pulse_q[P_OR];
    assign c21 = pulse_q[P_NOT];

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: behavioural ALU partner plus command-level
// reference of ACC/flags; honours ALU_DIVZERO_TRAP_EN.
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opc;
    logic [15:0] cmd_operand;
    logic [15:0] br_out;
    logic        c8, c9, c13, c15, c16, c17, c18, c19, c20, c21;
    logic [15:0] alu_out;
    logic [3:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;
    int multi_hot = 0;
    int plog[$];

    logic [15:0] ref_acc   = '0;
    logic [3:0]  ref_flags = '0;

    logic [9:0] pv;
    assign pv = {c21, c20, c19, c18, c17, c16, c15, c13, c9, c8};

    always #5 clk = ~clk;

    alu_op_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opc     (cmd_opc),
        .cmd_operand (cmd_operand),
        .br_out      (br_out),
        .c8          (c8),
        .c9          (c9),
        .c13         (c13),
        .c15         (c15),
        .c16         (c16),
        .c17         (c17),
        .c18         (c18),
        .c19         (c19),
        .c20         (c20),
        .c21         (c21),
        .alu_out     (alu_out),
        .alu_flags   (alu_flags),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_flags   (rsp_flags),
        .rsp_err     (rsp_err)
    );

    // Arithmetic meaning of each ALU operation; returns {ZF,CF,OF,SF,result}
    function automatic logic [19:0] alu_fn(input int op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            0: r = 16'h0000;
            1: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            2: begin
                r = a - b;
                c = (a < b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3: r = 16'(a * b);
            4: r = (b == 16'h0000) ? 16'hFFFF : a / b;
            5: r = a >> 1;
            6: r = a << 1;
            7: r = a & b;
            8: r = a | b;
            default: r = ~a;
        endcase
        return {(r == 16'h0000), c, v, r[15], r};
    endfunction

    function automatic int onehot_idx(input logic [9:0] v);
        int idx = 0;
        for (int i = 0; i < 10; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    // ALU partner: acts on whichever single pulse is present, resets with rst_n
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out   <= '0;
            alu_flags <= '0;
        end else if ($countones(pv) == 1) begin
            {alu_flags, alu_out} <= alu_fn(onehot_idx(pv), alu_out, br_out);
        end
    end

    always @(posedge clk) if (rst_n && $countones(pv) == 1) plog.push_back(onehot_idx(pv));
    always @(negedge clk) if ($countones(pv) > 1) multi_hot++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [3:0] opc, input logic [15:0] opnd, input int hold);
        logic [15:0] e_acc;
        logic [3:0]  e_flags;
        logic        e_err;
        logic        trap;
        logic [15:0] d0;
        logic [3:0]  f0;
        int e_lat, e_seq, lat, n, start, seq;
        trap = 1'b0;
`ifdef ALU_DIVZERO_TRAP_EN
        trap = (opc == 4'd4) && (opnd == 16'h0000);
`endif
        e_err = 1'b0;
        if (opc > 4'd10 || trap) begin
            e_err = 1'b1; e_acc = ref_acc; e_flags = ref_flags; e_lat = 1; e_seq = 0;
        end else if (opc == 4'd10) begin
            {e_flags, e_acc} = alu_fn(1, 16'h0000, opnd);
            e_lat = 4; e_seq = 1 * 16 + 2;
        end else begin
            {e_flags, e_acc} = alu_fn(int'(opc), ref_acc, opnd);
            e_lat = 3; e_seq = int'(opc) + 1;
        end
        ref_acc   = e_acc;
        ref_flags = e_flags;

        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_opc     = opc;
        cmd_operand = opnd;
        start = plog.size();
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        cmd_opc     = 4'($urandom);
        cmd_operand = 16'($urandom);

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 10);
        check("latency", 32'(lat), 32'(e_lat));

        d0 = rsp_data;
        f0 = rsp_flags;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            check("hold_data", 32'(rsp_data), 32'(d0));
            check("hold_flags", 32'(rsp_flags), 32'(f0));
            check("hold_ready", 32'({cmd_ready, rsp_valid}), 32'b01);
        end
        cmd_valid = 1'b0;

        check("rsp_data", 32'(rsp_data), 32'(e_acc));
        check("rsp_flags", 32'(rsp_flags), 32'(e_flags));
        check("rsp_err", 32'(rsp_err), 32'(e_err));
        check("br_out", 32'(br_out), 32'(opnd));
        seq = 0;
        for (int i = start; i < plog.size(); i++) seq = seq * 16 + plog[i] + 1;
        check("pulse_seq", 32'(seq), 32'(e_seq));

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  r_opc;
        logic [15:0] r_opnd;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_opc = '0; cmd_operand = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(cmd_ready), 32'd0);
        check("reset_outs", 32'({pv, rsp_valid, rsp_err, rsp_flags}), 32'd0);
        check("reset_data", 32'({br_out, rsp_data}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 32'(cmd_ready), 32'd1);
        check("post_reset_outs", 32'({pv, rsp_valid, rsp_err}), 32'd0);

        do_cmd(4'd10, 16'h0005, 0);
        do_cmd(4'd1,  16'h0003, 0);
        do_cmd(4'd10, 16'h7FFF, 0);
        do_cmd(4'd1,  16'h0001, 0);
        do_cmd(4'd2,  16'h8000, 0);
        do_cmd(4'd13, 16'h1234, 0);
        do_cmd(4'd10, 16'h00F0, 10);
        do_cmd(4'd4,  16'h0000, 2);
        do_cmd(4'd15, 16'hFFFF, 1);

        // Reset while the pulse is in flight
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opc = 4'd1; cmd_operand = 16'h0042;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("inflight_pulse", 32'(pv), 32'h002);
        rst_n = 1'b0;
        #1;
        check("reset_drop_pulse", 32'(pv), 32'd0);
        check("reset_drop_rsp", 32'({rsp_valid, cmd_ready}), 32'd0);
        ref_acc = '0;
        ref_flags = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(4'd1, 16'h0007, 0);

        for (int k = 0; k < 40; k++) begin
            r_opc  = 4'($urandom_range(0, 15));
            r_opnd = 16'($urandom);
            if (r_opc == 4'd4 && r_opnd == 16'h0000) r_opnd = 16'h0001;
            do_cmd(r_opc, r_opnd, int'($urandom_range(0, 2)));
        end

        check("one_hot_invariant", 32'(multi_hot), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
